hot_addr_ingress: RTL and testbench

Front-end of the page-hotness tracker. It turns raw memory-request byte addresses into cache-line addresses and applies read/write filtering, 1-in-N sampling and consecutive-duplicate merging. Survivors are buffered in a small FIFO and presented to the tracker core's `input_addr` valid/ready port. The memory path is never back-pressured: overflow is dropped and counted. The output holds each address one extra cycle after the handshake, because the tracker core writes `input_addr` into its CAM on the cycle after it accepts it.

---
 rtl/hot_track_pkg.sv | 25 ++
 rtl/hot_addr_fifo.sv | 58 +++++
 rtl/hot_addr_ingress.sv | 136 +++++++++++++
 tb/tb_hot_addr_ingress.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hot_track_pkg.sv
// Shared types for the page-hotness tracker ingress: output-stage states,
// request-filter mode encodings and the mode-match helper.
package hot_track_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PRESENT = 2'd1,
        HOLD    = 2'd2
    } out_state_e;

    localparam logic [1:0] MODE_ALL  = 2'd0;
    localparam logic [1:0] MODE_RD   = 2'd1;
    localparam logic [1:0] MODE_WR   = 2'd2;
    localparam logic [1:0] MODE_NONE = 2'd3;

    function automatic logic mode_match(input logic [1:0] mode, input logic is_write);
        case (mode)
            MODE_ALL: mode_match = 1'b1;
            MODE_RD:  mode_match = ~is_write;
            MODE_WR:  mode_match = is_write;
            default:  mode_match = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hot_addr_fifo.sv
// Synchronous FIFO for line addresses with registered occupancy and a
// synchronous clear. Writes to a full FIFO and reads of an empty one are ignored.
module hot_addr_fifo #(
    parameter int DEPTH    = 16,
    parameter int PTR_BITS = 4,
    parameter int WIDTH    = 28
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clear,
    input  logic                push,
    input  logic [WIDTH-1:0]    din,
    input  logic                pop,
    output logic [WIDTH-1:0]    dout,
    output logic                full,
    output logic                empty,
    output logic [PTR_BITS:0]   level
);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic                wr_en;
    logic                rd_en;

    assign full  = (level == (PTR_BITS+1)'(DEPTH));
    assign empty = (level == '0);
    assign wr_en = push & ~full & ~clear;
    assign rd_en = pop & ~empty & ~clear;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_BITS'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_BITS'(1);
            case ({wr_en, rd_en})
                2'b10:   level <= level + (PTR_BITS+1)'(1);
                2'b01:   level <= level - (PTR_BITS+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; occupancy is tracked by the
    // pointers and level, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/hot_addr_ingress.sv
// Ingress front-end of the page-hotness tracker: filters, samples and dedups
// request line addresses, buffers them and feeds the tracker core with a hold cycle.
module hot_addr_ingress
    import hot_track_pkg::*;
#(
    parameter int IN_ADDR_WIDTH = 52,
    parameter int ADDR_SIZE     = 28,
    parameter int ADDR_LSB      = 6,
    parameter int FIFO_DEPTH    = 16,
    parameter int FIFO_PTR_BITS = 4,
    parameter int SAMPLE_BITS   = 8,
    parameter int STAT_SIZE     = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     req_valid,
    input  logic [IN_ADDR_WIDTH-1:0] req_addr,
    input  logic                     req_is_write,
    input  logic                     cfg_enable,
    input  logic [1:0]               cfg_mode,
    input  logic [SAMPLE_BITS-1:0]   cfg_sample_period,
    input  logic                     flush,
    output logic [ADDR_SIZE-1:0]     out_addr,
    output logic                     out_addr_valid,
    input  logic                     out_addr_ready,
    output logic [FIFO_PTR_BITS:0]   fifo_level,
    output logic [STAT_SIZE-1:0]     drop_cnt,
    output logic [STAT_SIZE-1:0]     merge_cnt
);

    logic [ADDR_SIZE-1:0]   line;
    logic                   unused_addr_bits;
    logic                   candidate;
    logic                   sampled;
    logic                   dup;
    logic                   enq_req;
    logic                   drop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic [ADDR_SIZE-1:0]   fifo_head;
    logic [SAMPLE_BITS-1:0] samp_cnt;
    logic [ADDR_SIZE-1:0]   last_line;
    logic                   last_valid;
    out_state_e             state;
    out_state_e             state_nxt;

    assign line             = req_addr[ADDR_LSB +: ADDR_SIZE];
    assign unused_addr_bits = ^{req_addr[IN_ADDR_WIDTH-1:ADDR_LSB+ADDR_SIZE], req_addr[ADDR_LSB-1:0]};

    assign candidate = req_valid & cfg_enable & mode_match(cfg_mode, req_is_write);
    assign sampled   = candidate & (samp_cnt == '0);
    assign dup       = sampled & last_valid & (line == last_line);
    assign enq_req   = sampled & ~dup;
    // Full is judged before this cycle's pop, so a freed slot is not reusable yet.
    assign drop      = enq_req & fifo_full & ~flush;

    hot_addr_fifo #(
        .DEPTH    (FIFO_DEPTH),
        .PTR_BITS (FIFO_PTR_BITS),
        .WIDTH    (ADDR_SIZE)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clear (flush),
        .push  (enq_req),
        .din   (line),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            samp_cnt   <= '0;
            last_line  <= '0;
            last_valid <= 1'b0;
        end else if (flush) begin
            samp_cnt   <= '0;
            last_valid <= 1'b0;
        end else begin
            if (candidate)
                samp_cnt <= (samp_cnt == cfg_sample_period) ? '0 : samp_cnt + SAMPLE_BITS'(1);
            if (!cfg_enable) begin
                last_valid <= 1'b0;
            end else if (enq_req) begin
                last_line  <= line;
                last_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt  <= '0;
            merge_cnt <= '0;
        end else if (flush) begin
            drop_cnt  <= '0;
            merge_cnt <= '0;
        end else begin
            if (drop && drop_cnt != '1)  drop_cnt  <= drop_cnt + STAT_SIZE'(1);
            if (dup && merge_cnt != '1)  merge_cnt <= merge_cnt + STAT_SIZE'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= EMPTY;
        else       state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY:   if (!fifo_empty) state_nxt = PRESENT;
            PRESENT: if (out_addr_ready) state_nxt = HOLD;
            HOLD:    state_nxt = fifo_empty ? EMPTY : PRESENT;
            default: state_nxt = EMPTY;
        endcase
        if (flush) state_nxt = EMPTY;
    end

    always_comb begin
        out_addr_valid = (state == PRESENT);
        pop            = ~flush & ~fifo_empty & ((state == EMPTY) | (state == HOLD));
    end

    // out_addr only moves on the load edge, so it stays put through HOLD and EMPTY.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)    out_addr <= '0;
        else if (pop) out_addr <= fifo_head;
    end

endmodule

// File: tb/tb_hot_addr_ingress.sv
// Directed self-checking bench for hot_addr_ingress: inputs change and outputs
// are sampled on the falling edge, away from the active rising edge.
module tb_hot_addr_ingress;
    import hot_track_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic [51:0] req_addr;
    logic        req_is_write;
    logic        cfg_enable;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_sample_period;
    logic        flush;
    logic [27:0] out_addr;
    logic        out_addr_valid;
    logic        out_addr_ready;
    logic [4:0]  fifo_level;
    logic [31:0] drop_cnt;
    logic [31:0] merge_cnt;

    int checks   = 0;
    int failures = 0;
    logic [27:0] got[$];

    always #5 clk = ~clk;

    hot_addr_ingress dut (
        .clk               (clk),
        .rstn              (rstn),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_is_write      (req_is_write),
        .cfg_enable        (cfg_enable),
        .cfg_mode          (cfg_mode),
        .cfg_sample_period (cfg_sample_period),
        .flush             (flush),
        .out_addr          (out_addr),
        .out_addr_valid    (out_addr_valid),
        .out_addr_ready    (out_addr_ready),
        .fifo_level        (fifo_level),
        .drop_cnt          (drop_cnt),
        .merge_cnt         (merge_cnt)
    );

    function automatic logic [51:0] byte_addr(input logic [27:0] ln, input logic [5:0] off);
        byte_addr = {18'h0, ln, off};
    endfunction

    task automatic send_req(input logic [51:0] a, input logic w);
        req_valid    = 1'b1;
        req_addr     = a;
        req_is_write = w;
        @(negedge clk);
        req_valid    = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    // Accept everything for a bounded number of cycles, recording handshaked addresses.
    task automatic collect(input int cycles);
        got.delete();
        out_addr_ready = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            if (out_addr_valid) got.push_back(out_addr);
            @(negedge clk);
        end
        out_addr_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (out_addr !== 28'h0)   begin failures++; $display("FAIL reset_out_addr got=%h exp=0", out_addr); end
        checks++; if (out_addr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_addr_valid); end
        checks++; if (fifo_level !== 5'd0)  begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if (drop_cnt !== 32'd0)   begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
        checks++; if (merge_cnt !== 32'd0)  begin failures++; $display("FAIL reset_merge got=%0d exp=0", merge_cnt); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        send_req(52'h12_3456_7840, 1'b0);
        checks++; if (out_addr_valid !== 1'b0) begin failures++; $display("FAIL single_cycle1_valid got=%b exp=0", out_addr_valid); end
        @(negedge clk);
        checks++; if (out_addr_valid !== 1'b1) begin failures++; $display("FAIL single_cycle2_valid got=%b exp=1", out_addr_valid); end
        checks++; if (out_addr !== 28'h8D159E1) begin failures++; $display("FAIL single_cycle2_addr got=%h exp=8d159e1", out_addr); end
        out_addr_ready = 1'b1;
        @(negedge clk);
        out_addr_ready = 1'b0;
        checks++; if (out_addr_valid !== 1'b0) begin failures++; $display("FAIL single_hold_valid got=%b exp=0", out_addr_valid); end
        checks++; if (out_addr !== 28'h8D159E1) begin failures++; $display("FAIL single_hold_addr got=%h exp=8d159e1", out_addr); end
        @(negedge clk);
        checks++; if (out_addr_valid !== 1'b0) begin failures++; $display("FAIL single_empty_valid got=%b exp=0", out_addr_valid); end
        checks++; if (out_addr !== 28'h8D159E1) begin failures++; $display("FAIL single_empty_addr got=%h exp=8d159e1", out_addr); end
    endtask

    // 21 requests: the first is absorbed by the output stage, 16 fill the FIFO, 4 drop.
    task automatic test_back_to_back();
        for (int i = 0; i < 21; i++) send_req(byte_addr(28'h100 + 28'(i), 6'h0), 1'b0);
        checks++; if (fifo_level !== 5'd16) begin failures++; $display("FAIL b2b_level got=%0d exp=16", fifo_level); end
        checks++; if (drop_cnt !== 32'd4)   begin failures++; $display("FAIL b2b_drop got=%0d exp=4", drop_cnt); end
        checks++; if (out_addr !== 28'h100 || out_addr_valid !== 1'b1) begin failures++; $display("FAIL b2b_head got=%h/%b exp=100/1", out_addr, out_addr_valid); end
        // Handshake, then enqueue during HOLD while the FIFO is still full and being popped.
        out_addr_ready = 1'b1;
        @(negedge clk);
        out_addr_ready = 1'b0;
        send_req(byte_addr(28'h999, 6'h0), 1'b0);
        checks++; if (drop_cnt !== 32'd5)   begin failures++; $display("FAIL fullpop_drop got=%0d exp=5", drop_cnt); end
        checks++; if (fifo_level !== 5'd15) begin failures++; $display("FAIL fullpop_level got=%0d exp=15", fifo_level); end
        checks++; if (out_addr !== 28'h101) begin failures++; $display("FAIL fullpop_addr got=%h exp=101", out_addr); end
        collect(40);
        checks++; if (got.size() != 16) begin failures++; $display("FAIL drain_count got=%0d exp=16", got.size()); end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== 28'h101 + 28'(i)) begin failures++; $display("FAIL drain_order[%0d] got=%h exp=%h", i, got[i], 28'h101 + 28'(i)); end
        end
    endtask

    task automatic test_dedup();
        do_flush();
        for (int i = 0; i < 5; i++) send_req(byte_addr(28'hABC, 6'(i * 8)), 1'b0);
        checks++; if (merge_cnt !== 32'd4) begin failures++; $display("FAIL dedup_merge got=%0d exp=4", merge_cnt); end
        collect(10);
        checks++; if (got.size() != 1 || got[0] !== 28'hABC) begin failures++; $display("FAIL dedup_single got_n=%0d exp_n=1", got.size()); end
        send_req(byte_addr(28'h0A, 6'h0), 1'b1);
        send_req(byte_addr(28'h0B, 6'h0), 1'b1);
        send_req(byte_addr(28'h0A, 6'h0), 1'b1);
        collect(12);
        checks++; if (got.size() != 3) begin failures++; $display("FAIL dedup_aba_count got=%0d exp=3", got.size()); end
        else begin
            checks++; if (got[0] !== 28'h0A || got[1] !== 28'h0B || got[2] !== 28'h0A) begin failures++; $display("FAIL dedup_aba_order got=%h,%h,%h exp=a,b,a", got[0], got[1], got[2]); end
        end
        checks++; if (merge_cnt !== 32'd4) begin failures++; $display("FAIL dedup_merge_after got=%0d exp=4", merge_cnt); end
    endtask

    task automatic test_sampling();
        do_flush();
        cfg_sample_period = 8'd3;
        for (int i = 0; i < 12; i++) send_req(byte_addr(28'h200 + 28'(i), 6'h0), 1'b0);
        collect(12);
        checks++; if (got.size() != 3) begin failures++; $display("FAIL sample_count got=%0d exp=3", got.size()); end
        else begin
            checks++; if (got[0] !== 28'h200 || got[1] !== 28'h204 || got[2] !== 28'h208) begin failures++; $display("FAIL sample_order got=%h,%h,%h exp=200,204,208", got[0], got[1], got[2]); end
        end
        do_flush();
        cfg_mode = MODE_WR;
        for (int i = 0; i < 5; i++) send_req(byte_addr(28'h300 + 28'(i), 6'h0), 1'b0);
        @(negedge clk);
        checks++; if (fifo_level !== 5'd0 || out_addr_valid !== 1'b0) begin failures++; $display("FAIL mode_wr_forward got=%0d/%b exp=0/0", fifo_level, out_addr_valid); end
        checks++; if (drop_cnt !== 32'd0 || merge_cnt !== 32'd0) begin failures++; $display("FAIL mode_wr_counters got=%0d/%0d exp=0/0", drop_cnt, merge_cnt); end
        // Filtered reads must not advance the sampler: the next candidate is sampled.
        cfg_mode = MODE_ALL;
        send_req(byte_addr(28'h3FF, 6'h0), 1'b0);
        collect(6);
        checks++; if (got.size() != 1 || got[0] !== 28'h3FF) begin failures++; $display("FAIL mode_wr_sampler got_n=%0d exp_n=1", got.size()); end
        cfg_sample_period = 8'd0;
    endtask

    task automatic test_flush();
        do_flush();
        for (int i = 0; i < 6; i++) send_req(byte_addr(28'h400 + 28'(i), 6'h0), 1'b0);
        send_req(byte_addr(28'h405, 6'h0), 1'b0);
        checks++; if (fifo_level !== 5'd5 || out_addr_valid !== 1'b1 || merge_cnt !== 32'd1) begin failures++; $display("FAIL flush_setup got=%0d/%b/%0d exp=5/1/1", fifo_level, out_addr_valid, merge_cnt); end
        do_flush();
        checks++; if (out_addr_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_addr_valid); end
        checks++; if (fifo_level !== 5'd0)     begin failures++; $display("FAIL flush_level got=%0d exp=0", fifo_level); end
        checks++; if (merge_cnt !== 32'd0 || drop_cnt !== 32'd0) begin failures++; $display("FAIL flush_counters got=%0d/%0d exp=0/0", merge_cnt, drop_cnt); end
        flush = 1'b1;
        send_req(byte_addr(28'h500, 6'h0), 1'b0);
        flush = 1'b0;
        @(negedge clk);
        checks++; if (fifo_level !== 5'd0 || out_addr_valid !== 1'b0) begin failures++; $display("FAIL flush_override got=%0d/%b exp=0/0", fifo_level, out_addr_valid); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) send_req(byte_addr(28'h600 + 28'(i), 6'h0), 1'b0);
        #2 rstn = 1'b0;
        #1;
        checks++; if (out_addr !== 28'h0 || out_addr_valid !== 1'b0) begin failures++; $display("FAIL async_out got=%h/%b exp=0/0", out_addr, out_addr_valid); end
        checks++; if (fifo_level !== 5'd0 || drop_cnt !== 32'd0 || merge_cnt !== 32'd0) begin failures++; $display("FAIL async_stats got=%0d/%0d/%0d exp=0/0/0", fifo_level, drop_cnt, merge_cnt); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rstn              = 1'b0;
        req_valid         = 1'b0;
        req_addr          = '0;
        req_is_write      = 1'b0;
        cfg_enable        = 1'b1;
        cfg_mode          = MODE_ALL;
        cfg_sample_period = 8'd0;
        flush             = 1'b0;
        out_addr_ready    = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_read();
        test_back_to_back();
        test_dedup();
        test_sampling();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
